// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if: IR fields/ALU flags in, datapath control out, for the multi-cycle RV32I controller
interface multi_cycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             neg;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic [2:0]       ImmSrc;
    logic             illegal;
    logic [CNT_W-1:0] instrCount;
    modport master (
        input  op, funct3, funct7b5, zero, neg,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instrCount
    );
    modport slave (
        output op, funct3, funct7b5, zero, neg,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instrCount
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multi-cycle RV32I control FSM with retired-instruction counter; BRANCH_EXT_EN adds blt/bge
module multi_cycle_controller #(
    parameter int CNT_W = 32
) (
    input logic                      clk,
    input logic                      rst,
    multi_cycle_controller_if.master bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI
    } state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             pc_w, adr, mem_w, ir_w, reg_w, ill, f3_ok, br_ok, taken;
    logic [1:0]       res, sa, sb;
    logic [2:0]       alu, alu_f;
    assign f3_ok = bus.funct3 inside {3'b000, 3'b111, 3'b110, 3'b010};
    assign alu_f = (bus.funct3 == 3'b111) ? 3'b010 :
                   (bus.funct3 == 3'b110) ? 3'b011 :
                   (bus.funct3 == 3'b010) ? 3'b101 :
                   (bus.funct3 == 3'b000 && state_q == EXECR && bus.funct7b5) ? 3'b001 : 3'b000;
`ifdef BRANCH_EXT_EN
    assign br_ok = bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
    assign taken = br_ok & (bus.funct3[2] ? (bus.neg ^ bus.funct3[0]) : (bus.zero ^ bus.funct3[0]));
`else
    logic unused_neg;
    assign unused_neg = bus.neg;
    assign br_ok = bus.funct3 inside {3'b000, 3'b001};
    assign taken = br_ok & (bus.zero ^ bus.funct3[0]);
`endif
    assign bus.ImmSrc = (bus.op == OP_SW)  ? 3'b001 :
                        (bus.op == OP_BR)  ? 3'b010 :
                        (bus.op == OP_LUI) ? 3'b011 :
                        (bus.op == OP_JAL) ? 3'b100 : 3'b000;
    // State register and retired-instruction counter; rst aborts any instruction in flight
    always_ff @(posedge clk) begin
        state_q <= rst ? FETCH : state_d;
        count_q <= rst ? '0 : count_q + CNT_W'(state_d == FETCH && !ill);
    end
    // Next state and per-state control decode
    always_comb begin
        state_d = state_q;
        pc_w    = 1'b0;
        adr     = 1'b0;
        mem_w   = 1'b0;
        ir_w    = 1'b0;
        reg_w   = 1'b0;
        ill     = 1'b0;
        res     = 2'b00;
        sa      = 2'b00;
        sb      = 2'b00;
        alu     = 3'b000;
        case (state_q)
            FETCH: begin
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                sb      = 2'b10;
                res     = 2'b10;
                state_d = DECODE;
            end
            DECODE: begin
                sa = 2'b01;
                sb = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR1;
                    OP_LUI:       state_d = LUI;
                    default: begin
                        ill     = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                sa      = 2'b10;
                sb      = 2'b01;
                state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr     = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                res     = 2'b01;
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            MEMWRITE: begin
                adr     = 1'b1;
                mem_w   = 1'b1;
                state_d = FETCH;
            end
            EXECR, EXECI: begin
                sa      = 2'b10;
                sb      = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu     = alu_f;
                ill     = !f3_ok;
                state_d = f3_ok ? ALUWB : FETCH;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                sa      = 2'b10;
                alu     = 3'b001;
                pc_w    = taken;
                ill     = !br_ok;
                state_d = FETCH;
            end
            JAL, JALR2: begin
                pc_w    = 1'b1;
                sa      = 2'b01;
                sb      = 2'b10;
                state_d = ALUWB;
            end
            JALR1: begin
                sa      = 2'b10;
                sb      = 2'b01;
                state_d = JALR2;
            end
            LUI: begin
                res     = 2'b11;
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end
    assign bus.PCWrite    = pc_w & ~rst;
    assign bus.MemWrite   = mem_w & ~rst;
    assign bus.IRWrite    = ir_w & ~rst;
    assign bus.RegWrite   = reg_w & ~rst;
    assign bus.illegal    = ill & ~rst;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = res;
    assign bus.ALUSrcA    = sa;
    assign bus.ALUSrcB    = sb;
    assign bus.ALUControl = alu;
    assign bus.instrCount = count_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: per-cycle vector table plus instruction-length sequences
module tb_multi_cycle_controller;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
    localparam logic [6:0] XX = 7'b1111111;
    localparam logic [2:0] II = 3'b000, IS = 3'b001, IB = 3'b010, IU = 3'b011, IJ = 3'b100;
    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite}, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal
    localparam logic [14:0] S_F   = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [14:0] S_FR  = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [14:0] S_D   = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0};
    localparam logic [14:0] S_DI  = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b1};
    localparam logic [14:0] S_MA  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
    localparam logic [14:0] S_MR  = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [14:0] S_MWB = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [14:0] S_MWR = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [14:0] S_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
    localparam logic [14:0] S_RIL = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 1'b1};
    localparam logic [14:0] S_SLT = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b101, 1'b0};
    localparam logic [14:0] S_WB  = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [14:0] S_BN  = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
    localparam logic [14:0] S_BT  = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
    localparam logic [14:0] S_BI  = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b1};
    localparam logic [14:0] S_J   = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [14:0] S_LU  = {5'b00001, 2'b11, 2'b00, 2'b00, 3'b000, 1'b0};
`ifdef BRANCH_EXT_EN
    localparam logic [14:0] S_BLT = S_BT;
    localparam int EXT = 1;
`else
    localparam logic [14:0] S_BLT = S_BI;
    localparam int EXT = 0;
`endif
    typedef struct {
        logic        r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, z, n;
        logic [14:0] ctl;
        logic [2:0]  imm;
        logic [31:0] cnt;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    multi_cycle_controller_if #(.CNT_W(32)) bus ();
    multi_cycle_controller #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic f7, z, n,
                       input logic [14:0] ctl, input logic [2:0] imm, input int cnt);
        vec_t v;
        v.r = r; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
        v.ctl = ctl; v.imm = imm; v.cnt = 32'(cnt);
        tbl.push_back(v);
    endtask
    task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic f7, z, n);
        rst = r; bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z; bus.neg = n;
    endtask
    task automatic measure(input string name, input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int exp_cyc, input int exp_cnt);
        int n = 0;
        drive(1'b0, op, f3, 1'b0, z, 1'b0);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.IRWrite && n < 20);
        total++;
        if (n != exp_cyc) begin
            bad++;
            $display("FAIL %s cycles: got %0d want %0d", name, n, exp_cyc);
        end
        total++;
        if (bus.instrCount !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", name, bus.instrCount, exp_cnt);
        end
    endtask
    initial begin
        logic [14:0] act;
        drive(1'b1, LW, 3'b000, 1'b0, 1'b0, 1'b0);
        // reset, then lw
        add(1, LW, 0, 0, 0, 0, S_FR, II, 0);
        add(0, LW, 0, 0, 0, 0, S_F, II, 0);
        add(0, LW, 0, 0, 0, 0, S_D, II, 0);
        add(0, LW, 0, 0, 0, 0, S_MA, II, 0);
        add(0, LW, 0, 0, 0, 0, S_MR, II, 0);
        add(0, LW, 0, 0, 0, 0, S_MWB, II, 0);
        // sw
        add(0, SW, 2, 0, 0, 0, S_F, IS, 1);
        add(0, SW, 2, 0, 0, 0, S_D, IS, 1);
        add(0, SW, 2, 0, 0, 0, S_MA, IS, 1);
        add(0, SW, 2, 0, 0, 0, S_MWR, IS, 1);
        // sub
        add(0, RT, 0, 1, 0, 0, S_F, II, 2);
        add(0, RT, 0, 1, 0, 0, S_D, II, 2);
        add(0, RT, 0, 1, 0, 0, S_SUB, II, 2);
        add(0, RT, 0, 1, 0, 0, S_WB, II, 2);
        // slti
        add(0, IT, 2, 1, 0, 0, S_F, II, 3);
        add(0, IT, 2, 1, 0, 0, S_D, II, 3);
        add(0, IT, 2, 1, 0, 0, S_SLT, II, 3);
        add(0, IT, 2, 1, 0, 0, S_WB, II, 3);
        // beq not taken, beq taken, bne taken, blt with neg=1
        add(0, BR, 0, 0, 0, 0, S_F, IB, 4);
        add(0, BR, 0, 0, 0, 0, S_D, IB, 4);
        add(0, BR, 0, 0, 0, 0, S_BN, IB, 4);
        add(0, BR, 0, 0, 1, 0, S_F, IB, 5);
        add(0, BR, 0, 0, 1, 0, S_D, IB, 5);
        add(0, BR, 0, 0, 1, 0, S_BT, IB, 5);
        add(0, BR, 1, 0, 0, 0, S_F, IB, 6);
        add(0, BR, 1, 0, 0, 0, S_D, IB, 6);
        add(0, BR, 1, 0, 0, 0, S_BT, IB, 6);
        add(0, BR, 4, 0, 0, 1, S_F, IB, 7);
        add(0, BR, 4, 0, 0, 1, S_D, IB, 7);
        add(0, BR, 4, 0, 0, 1, S_BLT, IB, 7);
        // jal
        add(0, JL, 0, 0, 0, 0, S_F, IJ, 7 + EXT);
        add(0, JL, 0, 0, 0, 0, S_D, IJ, 7 + EXT);
        add(0, JL, 0, 0, 0, 0, S_J, IJ, 7 + EXT);
        add(0, JL, 0, 0, 0, 0, S_WB, IJ, 7 + EXT);
        // jalr
        add(0, JR, 0, 0, 0, 0, S_F, II, 8 + EXT);
        add(0, JR, 0, 0, 0, 0, S_D, II, 8 + EXT);
        add(0, JR, 0, 0, 0, 0, S_MA, II, 8 + EXT);
        add(0, JR, 0, 0, 0, 0, S_J, II, 8 + EXT);
        add(0, JR, 0, 0, 0, 0, S_WB, II, 8 + EXT);
        // lui
        add(0, LU, 0, 0, 0, 0, S_F, IU, 9 + EXT);
        add(0, LU, 0, 0, 0, 0, S_D, IU, 9 + EXT);
        add(0, LU, 0, 0, 0, 0, S_LU, IU, 9 + EXT);
        // illegal opcode, then R-type with unsupported funct3
        add(0, XX, 0, 0, 0, 0, S_F, II, 10 + EXT);
        add(0, XX, 0, 0, 0, 0, S_DI, II, 10 + EXT);
        add(0, RT, 1, 0, 0, 0, S_F, II, 10 + EXT);
        add(0, RT, 1, 0, 0, 0, S_D, II, 10 + EXT);
        add(0, RT, 1, 0, 0, 0, S_RIL, II, 10 + EXT);
        // lw aborted by 3-cycle reset in MEMREAD, then lui
        add(0, LW, 0, 0, 0, 0, S_F, II, 10 + EXT);
        add(0, LW, 0, 0, 0, 0, S_D, II, 10 + EXT);
        add(0, LW, 0, 0, 0, 0, S_MA, II, 10 + EXT);
        add(1, LW, 0, 0, 0, 0, S_MR, II, 10 + EXT);
        add(1, LW, 0, 0, 0, 0, S_FR, II, 0);
        add(1, LW, 0, 0, 0, 0, S_FR, II, 0);
        add(0, LU, 0, 0, 0, 0, S_F, IU, 0);
        add(0, LU, 0, 0, 0, 0, S_D, IU, 0);
        add(0, LU, 0, 0, 0, 0, S_LU, IU, 0);
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].n);
            #1;
            act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.illegal};
            total++;
            if ({act, bus.ImmSrc} !== {tbl[i].ctl, tbl[i].imm}) begin
                bad++;
                $display("FAIL vec%0d ctl: got %b/%b want %b/%b", i, act, bus.ImmSrc, tbl[i].ctl, tbl[i].imm);
            end
            total++;
            if (bus.instrCount !== tbl[i].cnt) begin
                bad++;
                $display("FAIL vec%0d count: got %0d want %0d", i, bus.instrCount, tbl[i].cnt);
            end
            @(posedge clk);
            #1;
        end
        measure("lui", LU, 3'b000, 1'b0, 3, 2);
        measure("illop", XX, 3'b000, 1'b0, 2, 2);
        measure("jalr", JR, 3'b000, 1'b0, 5, 3);
        measure("sw", SW, 3'b010, 1'b0, 4, 4);
        measure("beq", BR, 3'b000, 1'b1, 3, 5);
        measure("lw", LW, 3'b010, 1'b0, 5, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
